pipe_skid_stage: RTL and testbench

Parametrised ready/valid pipeline stage that replaces the fixed stall/flush inter-stage registers between the IF/ID/EX/MEM/WB boundaries. It carries a configurable-width payload (packed instruction fields, operands, control bits), adds backpressure via a valid/ready handshake, and supports synchronous flush. An optional two-entry skid mode registers `in_ready`, so no combinational path runs from downstream stall to upstream stall.

---
 rtl/pipe_skid_stage.sv | 119 +++++++++++
 tb/tb_pipe_skid_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: ready/valid pipeline register with synchronous flush.
//
// SKID=1 selects a two-entry skid buffer. In this mode in_ready depends only
// on registered state, so a downstream stall never reaches upstream
// combinationally. SKID=0 selects a single register, and its in_ready is
// combinational from out_ready.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   flush      synchronous flush; drops all held entries
//   in_valid   upstream offers in_data
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts this cycle
//   out_data   head payload
//   count      entries held (0..2 with SKID=1, 0..1 with SKID=0)
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  // Second entry. It is only ever loaded in skid mode; with SKID=0 it stays
  // at zero and synthesis removes it.
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  // The encoding is chosen so that the state value equals the number of
  // held entries.
  assign count     = state_q;

  if (SKID != 0) begin : g_ready_skid
    assign in_ready = rst & (state_q != StFull);
  end else begin : g_ready_reg
    assign in_ready = rst & (~out_valid | out_ready);
  end

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A concurrent accept is dropped. A concurrent fire was already
      // presented downstream this cycle.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else if (SKID != 0) begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && fire) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end else begin
      if (accept) begin
        main_d  = in_data;
        state_d = StOne;
      end else if (fire) begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. Two instances share the stimulus: a 64-bit skid
// stage (sel=0) and an 8-bit single-register stage (sel=1). A negedge
// monitor keeps a queue of expected entries for the selected instance. It
// checks handshake, count, head data and stall stability. Scenario tasks add
// directed checks.
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        sel;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [1:0]  s_count;
  logic        r_in_ready, r_out_valid;
  logic [7:0]  r_out_data;
  logic [1:0]  r_count;

  logic        o_in_ready, o_valid;
  logic [63:0] o_data;
  logic [1:0]  o_count;

  int n_checks;
  int n_errors;

  logic [63:0] sb[$];
  logic        prev_stall;
  logic [63:0] prev_data;
  logic        exp_rdy;
  logic        m_acc;
  logic        m_fire;
  logic [63:0] mask;

  pipe_skid_stage #(.WIDTH(64), .SKID(1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .count     (s_count)
  );

  pipe_skid_stage #(.WIDTH(8), .SKID(0)) u_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (r_in_ready),
    .in_data   (in_data[7:0]),
    .out_valid (r_out_valid),
    .out_ready (out_ready),
    .out_data  (r_out_data),
    .count     (r_count)
  );

  assign o_in_ready = sel ? r_in_ready : s_in_ready;
  assign o_valid    = sel ? r_out_valid : s_out_valid;
  assign o_data     = sel ? {56'd0, r_out_data} : s_out_data;
  assign o_count    = sel ? r_count : s_count;

  always #5 clk = ~clk;

  // Scoreboard monitor: inputs are stable at the negedge, so the model
  // predicts this cycle's outputs and then applies the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      mask    = sel ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF;
      exp_rdy = sel ? ((sb.size() == 0) || out_ready) : (sb.size() < 2);
      n_checks++;
      if (o_in_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL sb_in_ready sel=%0d: got %0b expected %0b", sel, o_in_ready, exp_rdy);
      end
      n_checks++;
      if (o_valid !== (sb.size() != 0)) begin
        n_errors++;
        $display("FAIL sb_out_valid sel=%0d: got %0b expected %0b", sel, o_valid,
                 (sb.size() != 0));
      end
      n_checks++;
      if (o_count !== 2'(sb.size())) begin
        n_errors++;
        $display("FAIL sb_count sel=%0d: got %0d expected %0d", sel, o_count, sb.size());
      end
      if (sb.size() != 0) begin
        n_checks++;
        if (o_data !== sb[0]) begin
          n_errors++;
          $display("FAIL sb_out_data sel=%0d: got %0h expected %0h", sel, o_data, sb[0]);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (o_data !== prev_data || o_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL stall_stable sel=%0d: got %0h/%0b expected %0h/1", sel, o_data,
                   o_valid, prev_data);
        end
      end
      m_acc      = in_valid && exp_rdy;
      m_fire     = (sb.size() != 0) && out_ready;
      prev_stall = (sb.size() != 0) && !out_ready && !flush;
      prev_data  = o_data;
      if (flush) begin
        sb.delete();
      end else begin
        if (m_fire) void'(sb.pop_front());
        if (m_acc) sb.push_back(in_data & mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    sel = s;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (o_in_ready !== 1'b0 || o_valid !== 1'b0 || o_count !== 2'd0 || o_data !== 64'd0) begin
        n_errors++;
        $display("FAIL reset_hold: got rdy=%0b vld=%0b cnt=%0d data=%0h expected 0/0/0/0",
                 o_in_ready, o_valid, o_count, o_data);
      end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got rdy=%0b vld=%0b expected 1/0", o_in_ready, o_valid);
    end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 64'(i);
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== 64'(i) || o_count !== 2'd1) begin
        n_errors++;
        $display("FAIL stream_%0d: got vld=%0b data=%0h cnt=%0d expected 1/%0h/1", i, o_valid,
                 o_data, o_count, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid_fill();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hA;
    tick();
    in_data = 64'hB;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL skid_rdy_lag: got %0b expected 1", o_in_ready);
    end
    tick();
    in_data = 64'hC;
    #1;
    n_checks++;
    if (o_count !== 2'd2 || o_in_ready !== 1'b0 || o_data !== 64'hA) begin
      n_errors++;
      $display("FAIL skid_full: got cnt=%0d rdy=%0b data=%0h expected 2/0/a", o_count,
               o_in_ready, o_data);
    end
    tick();
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (o_data !== 64'hA || o_count !== 2'd2) begin
      n_errors++;
      $display("FAIL skid_head_a: got %0h cnt=%0d expected a/2", o_data, o_count);
    end
    tick();
    n_checks++;
    if (o_data !== 64'hB || o_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL skid_head_b: got %0h vld=%0b expected b/1", o_data, o_valid);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (o_data !== 64'hC || o_valid !== 1'b1 || o_count !== 2'd1) begin
      n_errors++;
      $display("FAIL skid_head_c: got %0h vld=%0b cnt=%0d expected c/1/1", o_data, o_valid,
               o_count);
    end
    tick();
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    flush = 1'b1;
    in_data = 64'hC;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || o_data === 64'hC) begin
      n_errors++;
      $display("FAIL flush_full: got vld=%0b cnt=%0d data=%0h expected 0/0/not-c", o_valid,
               o_count, o_data);
    end
    in_valid = 1'b1;
    in_data = 64'hD;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 64'hD || o_count !== 2'd1) begin
      n_errors++;
      $display("FAIL flush_then_d: got vld=%0b data=%0h cnt=%0d expected 1/d/1", o_valid,
               o_data, o_count);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_skid0();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h5;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 64'h5 || o_in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reg_stall: got vld=%0b data=%0h rdy=%0b expected 1/5/0", o_valid,
               o_data, o_in_ready);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 64'h6;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reg_rdy_comb: got %0b expected 1", o_in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 64'h6 || o_count !== 2'd1) begin
      n_errors++;
      $display("FAIL reg_pass: got vld=%0b data=%0h cnt=%0d expected 1/6/1", o_valid, o_data,
               o_count);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      n_errors++;
      $display("FAIL reg_drain: got vld=%0b cnt=%0d expected 0/0", o_valid, o_count);
    end
  endtask

  task automatic test_soak();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = {$urandom(), $urandom()};
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 2'd0 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL soak_drain sel=%0d: got vld=%0b cnt=%0d sb=%0d expected 0/0/0", sel,
               o_valid, o_count, sb.size());
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 64'd0;
    out_ready = 1'b0;
    sel = 1'b0;
    n_checks = 0;
    n_errors = 0;
    prev_stall = 1'b0;
    prev_data = 64'd0;
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush_full();
    test_soak();
    do_reset(1'b1);
    test_skid0();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
